// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte and 16-byte block payloads.
package aes_pkg;

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned BYTE_W    = 8;

    typedef logic [BYTE_W-1:0]           byte_t;
    typedef byte_t [BLK_BYTES-1:0]       block_t;

    // Counter width for a block of n bytes; at least one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_reg16_1to16_if.sv
// Byte-in / block-out bundle of the 1-to-16 deserializer.
interface mod_reg16_1to16_if
    import aes_pkg::*;
#(
    parameter int unsigned N = BLK_BYTES,
    parameter int unsigned W = BYTE_W
);
    localparam int unsigned NW = cnt_w(N);

    logic                  wr_en;
    logic [W-1:0]          i;
    logic                  clr;
    logic                  rd_en;
    logic                  in_ready;
    logic [N-1:0][W-1:0]   o;
    logic                  reg_full;
    logic [NW-1:0]         n_wr;
    logic                  err_ovf;

    // Producer/consumer side driving the deserializer.
    modport master (
        output wr_en, i, clr, rd_en,
        input  in_ready, o, reg_full, n_wr, err_ovf
    );

    // Deserializer side.
    modport slave (
        input  wr_en, i, clr, rd_en,
        output in_ready, o, reg_full, n_wr, err_ovf
    );

endinterface

// File: rtl/mod_reg16_1to16.sv
// Byte-wise deserializer: gathers N bytes into one parallel block with
// valid/ready style handshakes on both sides and a sticky overflow flag.
module mod_reg16_1to16
    import aes_pkg::*;
#(
    parameter int unsigned N = BLK_BYTES,
    parameter int unsigned W = BYTE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_reg16_1to16_if.slave     bus
);

    localparam int unsigned NW   = cnt_w(N);
    localparam logic [0:0]  FILL = 1'b0;
    localparam logic [0:0]  FULL = 1'b1;

    logic [0:0]          r_state;
    logic [NW-1:0]       r_nwr;
    logic [N-1:0][W-1:0] r_buf;
    logic                r_ovf;

    logic [0:0]          w_state_nxt;
    logic [NW-1:0]       w_nwr_nxt;
    logic [N-1:0][W-1:0] w_buf_nxt;
    logic                w_ovf_nxt;

    // State, counter, buffer and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_nwr   <= '0;
            r_buf   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_nwr   <= w_nwr_nxt;
            r_buf   <= w_buf_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state logic; clr beats wr_en in FILL, a full block is released only by rd_en.
    always_comb begin
        w_state_nxt = r_state;
        w_nwr_nxt   = r_nwr;
        w_buf_nxt   = r_buf;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            FILL: begin
                if (bus.clr) begin
                    w_nwr_nxt = '0;
                end else if (bus.wr_en) begin
                    w_buf_nxt[r_nwr] = bus.i;
                    if (r_nwr == NW'(N - 1)) begin
                        w_nwr_nxt   = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_nwr_nxt = r_nwr + NW'(1);
                    end
                end
            end
            FULL: begin
                if (bus.rd_en) begin
                    w_state_nxt = FILL;
                    if (bus.wr_en) begin
                        w_buf_nxt[0] = bus.i;
                        w_nwr_nxt    = NW'(1);
                    end else begin
                        w_nwr_nxt = '0;
                    end
                end else if (bus.wr_en) begin
                    w_ovf_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_nwr_nxt   = '0;
            end
        endcase
    end

    assign bus.o        = r_buf;
    assign bus.reg_full = (r_state == FULL);
    assign bus.n_wr     = r_nwr;
    assign bus.err_ovf  = r_ovf;
    assign bus.in_ready = (r_state != FULL) || bus.rd_en;

endmodule

// File: tb/tb_mod_reg16_1to16.sv
// Scoreboard bench for the 1-to-16 byte deserializer.
module tb_mod_reg16_1to16;
    import aes_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    block_t exp_q[$];
    block_t last_blk;

    mod_reg16_1to16_if #(.N(16), .W(8)) bus ();

    mod_reg16_1to16 #(.N(16), .W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write blk[from..to-1] on consecutive cycles; a completing write queues the block.
    task automatic feed(input block_t blk, input int from, input int to);
        for (int k = from; k < to; k++) begin
            bus.wr_en = 1'b1;
            bus.i     = blk[k];
            if (k == 15) exp_q.push_back(blk);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    function automatic block_t ramp(input byte_t base);
        block_t b;
        for (int k = 0; k < 16; k++) b[k] = base + byte_t'(k);
        return b;
    endfunction

    // Pop the expected block once reg_full is seen (bounded wait).
    task automatic check_full(input string name);
        block_t exp;
        int     waited;
        waited = 0;
        while (bus.reg_full !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        n_chk++;
        if (bus.reg_full !== 1'b1 || waited != 0) begin
            n_fail++;
            $display("FAIL %s_full: reg_full=%b after %0d extra cycles, required 1 at once", name, bus.reg_full, waited);
        end
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_queue: no expected block queued", name);
        end else begin
            exp = exp_q.pop_front();
            last_blk = exp;
            if (bus.o !== exp) begin
                n_fail++;
                $display("FAIL %s_block: o=%h required %h", name, bus.o, exp);
            end
        end
        n_chk++;
        if (bus.n_wr !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_nwr: n_wr=%0d required 0", name, bus.n_wr);
        end
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if (bus.reg_full !== 1'b0 || bus.n_wr !== 4'd0 || bus.err_ovf !== 1'b0 || bus.o !== '0) begin
            n_fail++;
            $display("FAIL %s: full=%b n_wr=%0d ovf=%b o=%h required 0/0/0/0",
                     name, bus.reg_full, bus.n_wr, bus.err_ovf, bus.o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("reset_state");
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_fill();
        block_t b;
        b = ramp(8'h00);
        feed(b, 0, 15);
        n_chk++;
        if (bus.n_wr !== 4'd15 || bus.reg_full !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_15: n_wr=%0d full=%b required 15/0", bus.n_wr, bus.reg_full);
        end
        feed(b, 15, 16);
        check_full("fill");
        n_chk++;
        if (bus.o[0] !== 8'h00 || bus.o[15] !== 8'h0F) begin
            n_fail++;
            $display("FAIL fill_ends: o[0]=%h o[15]=%h required 00/0f", bus.o[0], bus.o[15]);
        end
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_in_ready: got %b required 0", bus.in_ready);
        end
    endtask

    task automatic test_read_then_write();
        block_t b;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_chk++;
        if (bus.reg_full !== 1'b0 || bus.n_wr !== 4'd0 || bus.o[1] !== 8'h01) begin
            n_fail++;
            $display("FAIL read_release: full=%b n_wr=%0d o[1]=%h required 0/0/01",
                     bus.reg_full, bus.n_wr, bus.o[1]);
        end
        b = ramp(8'h10);
        b[0] = 8'hA5;
        feed(b, 0, 1);
        n_chk++;
        if (bus.o[0] !== 8'hA5 || bus.n_wr !== 4'd1) begin
            n_fail++;
            $display("FAIL read_write_a5: o[0]=%h n_wr=%0d required a5/1", bus.o[0], bus.n_wr);
        end
        feed(b, 1, 16);
        check_full("refill_a5");
    endtask

    task automatic test_back_to_back();
        block_t b;
        b = ramp(8'h20);
        b[0] = 8'h3C;
        bus.rd_en = 1'b1;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready);
        end
        bus.wr_en = 1'b1;
        bus.i     = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        n_chk++;
        if (bus.reg_full !== 1'b0 || bus.o[0] !== 8'h3C || bus.n_wr !== 4'd1 || bus.err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_consume: full=%b o[0]=%h n_wr=%0d ovf=%b required 0/3c/1/0",
                     bus.reg_full, bus.o[0], bus.n_wr, bus.err_ovf);
        end
        feed(b, 1, 16);
        check_full("b2b");
    endtask

    task automatic test_overflow();
        bus.wr_en = 1'b1;
        bus.i     = 8'hFF;
        tick();
        bus.wr_en = 1'b0;
        n_chk++;
        if (bus.err_ovf !== 1'b1 || bus.reg_full !== 1'b1 || bus.o !== last_blk) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf=%b full=%b o=%h required 1/1/%h",
                     bus.err_ovf, bus.reg_full, bus.o, last_blk);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        feed(ramp(8'h40), 0, 16);
        check_full("ovf_refill");
        n_chk++;
        if (bus.err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b required 1", bus.err_ovf);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("ovf_reset");
    endtask

    task automatic test_clr();
        feed(ramp(8'h50), 0, 5);
        n_chk++;
        if (bus.n_wr !== 4'd5) begin
            n_fail++;
            $display("FAIL clr_pre: n_wr=%0d required 5", bus.n_wr);
        end
        bus.clr   = 1'b1;
        bus.wr_en = 1'b1;
        bus.i     = 8'h77;
        tick();
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        n_chk++;
        if (bus.n_wr !== 4'd0 || bus.o[5] !== 8'h00 || bus.o[0] !== 8'h50) begin
            n_fail++;
            $display("FAIL clr_drop: n_wr=%0d o[5]=%h o[0]=%h required 0/00/50",
                     bus.n_wr, bus.o[5], bus.o[0]);
        end
        feed(ramp(8'h60), 0, 16);
        check_full("clr_refill");
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n_chk++;
        if (bus.reg_full !== 1'b1 || bus.o !== last_blk) begin
            n_fail++;
            $display("FAIL clr_full_ignored: full=%b o=%h required 1/%h", bus.reg_full, bus.o, last_blk);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset_cases();
        feed(ramp(8'h80), 0, 9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("reset_midfill");
        feed(ramp(8'h90), 0, 16);
        check_full("post_reset_fill");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("reset_full");
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.i     = '0;
        bus.clr   = 1'b0;
        bus.rd_en = 1'b0;
        last_blk  = '0;
        tick();
        test_reset();
        test_fill();
        test_read_then_write();
        test_back_to_back();
        test_overflow();
        test_clr();
        test_reset_cases();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d blocks left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_reg16_1to16.md
Name: mod_reg16_1to16

Overview:
- Byte-wise deserializer: collects N consecutive bytes from a byte stream and presents them as one parallel N-byte block.
- Inverse of the 16-to-1 serializer register. Sits on the AES datapath input side, for example FIFO byte stream into a 128-bit state.
- Simple valid/ready-style handshake on both sides: byte in, block out.

Parameters:
- N, 16, number of bytes per block (power of two, at most 16).
- W, 8, bits per byte.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- i  in  W  input byte.
- wr_en  in  1  input byte valid; byte accepted on an edge where wr_en && in_ready.
- clr  in  1  synchronous discard of a partially filled block.
- rd_en  in  1  consumer takes the block; effective only while reg_full.
- in_ready  out  1  block can accept a byte this cycle; combinational: !reg_full || rd_en.
- o  out  [N-1:0][W-1:0]  assembled block; byte k is the k-th byte received.
- reg_full  out  1  block complete and held for the consumer.
- n_wr  out  $clog2(N)  number of bytes currently stored (0..N-1); 0 while full.
- err_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (sync, when reset is high at a clk edge): o = 0 for all bytes, n_wr = 0, reg_full = 0, err_ovf = 0, state = FILL. Reset overrides all other inputs, including mid-fill and while full.
- States: FILL (reg_full = 0) and FULL (reg_full = 1).
- FILL, wr_en high:
  - o[n_wr] <= i.
  - If n_wr == N-1: n_wr <= 0, reg_full <= 1 (go to FULL) on that same edge.
  - Otherwise n_wr <= n_wr + 1.
- FILL, wr_en low: hold.
- FILL, rd_en: ignored.
- Latency: the block is visible with reg_full = 1 in the cycle after the edge that captured the N-th byte.
- FULL, rd_en high, wr_en low: reg_full <= 0, go to FILL. o keeps its stale value until overwritten byte by byte.
- FULL, rd_en high and wr_en high (simultaneous): the block is consumed, and i is written to o[0] as byte 0 of the next block. n_wr <= 1, state = FILL. No bubble.
- FULL, wr_en high, rd_en low: byte dropped, err_ovf <= 1 (sticky until reset), o unchanged.
- FULL, neither asserted: hold o and reg_full.
- clr (FILL only): n_wr <= 0. clr has priority over wr_en in the same cycle, so that byte is discarded. o contents are not cleared.
- clr while FULL: ignored. A completed block is released only via rd_en or reset.
- n_wr wraps only through the N-1 → 0 completion path and never increments past N-1.
- All outputs are registered except in_ready.

Decomposition:
- Shared package aes_pkg holds:
  - localparams BLK_BYTES = 16 and BYTE_W = 8;
  - typedef byte_t = logic [7:0];
  - typedef block_t = byte_t [15:0].
- No sub-module needed: one always_ff for the state, counter and buffer, plus one continuous assign for in_ready.

Test Plan:
- Reset, then 16 writes of 8'h00..8'h0F on back-to-back cycles → reg_full = 1 one cycle after the 16th edge. o[0] = 8'h00, o[15] = 8'h0F, n_wr = 0.
- While FULL, pulse rd_en with wr_en = 0 → next cycle reg_full = 0, n_wr = 0. Then write 8'hA5 → o[0] = 8'hA5, n_wr = 1.
- While FULL, wr_en = 1 with i = 8'h3C and rd_en = 1 in the same cycle → reg_full = 0, o[0] = 8'h3C, n_wr = 1, err_ovf = 0.
- While FULL, wr_en = 1 with rd_en = 0 and i = 8'hFF → o unchanged, err_ovf = 1 and stays 1 through a later rd_en and refill until reset.
- Write 5 bytes, then assert clr and wr_en together (i = 8'h77) → n_wr = 0 and the byte is dropped. The next 16 bytes fill o[0..15] correctly.
- Assert reset after 9 bytes written, and again while FULL → next cycle n_wr = 0, reg_full = 0, err_ovf = 0, o all 8'h00.
